// File: rtl/pwm_dac_fifo.sv
// PWM audio DAC with a small sample FIFO, edge/center-aligned modulation and underrun counting.
// Optional build macro PWM_DAC_UNDERRUN_MIDSCALE_EN: on underrun load midscale instead of holding.
module pwm_dac_fifo #(
  parameter int unsigned CODE_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CODE_WIDTH-1:0]         in_code,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          center_mode,
  input  logic                          mute,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = AddrW + 1;
  localparam logic [CODE_WIDTH-1:0] Midscale = {1'b1, {(CODE_WIDTH-1){1'b0}}};

  logic [CODE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]     level_q, level_d;
  logic                  full, empty, push, pop, boundary;

  logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
  logic [CODE_WIDTH-1:0] duty_q, duty_d;
  logic                  mode_q, mode_d;
  logic                  mute_q, mute_d;
  logic                  pwm_q, pwm_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ucnt_q, ucnt_d;
  logic [CODE_WIDTH:0]   lo, hi, cnt_ext;

  assign full     = (level_q == LevelW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = ~full;
  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push     = in_valid & ~full;
  assign boundary = &cnt_q;
  assign pop      = boundary & ~empty;

  assign pwm_out      = pwm_q;
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    mode_d = mode_q;
    mute_d = mute_q;
    if (boundary) begin
      mode_d = center_mode;
      mute_d = mute;
      if (mute) begin
        duty_d = '0;
      end else if (!empty) begin
        duty_d = mem_q[rd_ptr_q];
      end else begin
`ifdef PWM_DAC_UNDERRUN_MIDSCALE_EN
        duty_d = Midscale;
`else
        duty_d = duty_q;
`endif
      end
    end
  end

  // Center window: [2^(W-1) - duty/2, that + duty), one bit wider so the upper bound cannot wrap.
  always_comb begin
    cnt_ext = {1'b0, cnt_q};
    lo      = {1'b0, Midscale} - {2'b00, duty_q[CODE_WIDTH-1:1]};
    hi      = lo + {1'b0, duty_q};
    if (mode_q) begin
      pwm_d = (cnt_ext >= lo) && (cnt_ext < hi);
    end else begin
      pwm_d = (cnt_q < duty_q);
    end
    pwm_d = pwm_d & ~mute_q;
  end

  always_comb begin
    cnt_d      = cnt_q + CODE_WIDTH'(1);
    underrun_d = boundary & empty;
    ucnt_d     = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Sample storage carries no reset; entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      mode_q     <= 1'b0;
      mute_q     <= 1'b0;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      mode_q     <= mode_d;
      mute_q     <= mute_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

endmodule

// File: doc/pwm_dac_fifo.md
# pwm_dac_fifo

Single-clock PWM audio DAC with an input sample FIFO. It is the parametrised successor to the fixed 10-bit sampler, with configurable code width, buffer depth, run-time edge- or center-aligned modulation, and underrun detection and counting. It sits in the PWM clock domain between the scaler output and the IOB flop that drives `AUD_PWM`. It exposes a valid/ready sink toward the synth path and pulls one sample per PWM period.

## Interface
- `CODE_WIDTH`, 10: bits per sample code. The PWM period is 2^CODE_WIDTH cycles. Legal range is 4..12.
- `FIFO_DEPTH`, 4: sample buffer entries. Must be a power of two, at least 2.
- `clk` input, 1 bit: PWM clock. All state is on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset. Assertion is asynchronous; the reset is externally synchronised for deassertion.
- `in_code` input, CODE_WIDTH bits: unsigned sample code.
- `in_valid` input, 1 bit: `in_code` is valid.
- `in_ready` output, 1 bit: FIFO can accept a sample. Combinational, equal to !full.
- `center_mode` input, 1 bit: 0 selects edge-aligned PWM, 1 selects center-aligned. Sampled only at period boundaries.
- `mute` input, 1 bit: forces the loaded duty to 0. Sampled only at period boundaries. The FIFO still pops.
- `pwm_out` output, 1 bit: registered PWM bit.
- `fifo_level` output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
- `underrun` output, 1 bit: one-cycle registered pulse.
- `underrun_cnt` output, 16 bits: saturating count of underruns.

## Operation
- Push: a sample is written when `in_valid && in_ready`. There is no bypass. A full FIFO refuses a push even if a pop occurs in the same cycle.
- Counter: `cnt` is CODE_WIDTH bits and free-runs from 0 to 2^CODE_WIDTH-1, then wraps to 0.
- Boundary cycle: the cycle where `cnt` == all-ones. On this cycle the block:
  - pops one entry if the FIFO is non-empty;
  - loads `duty`, `mode_q` and `mute_q`.
- If `mute` is set, the loaded duty is 0. Otherwise it is the popped code.
- Empty FIFO at boundary (underrun):
  - `duty` holds its previous value (see Configuration);
  - `underrun` pulses on the next cycle;
  - `underrun_cnt` increments and saturates at 0xFFFF.
- Push and pop in the same cycle: both are performed and `fifo_level` is unchanged.
- Push into an empty FIFO on a boundary cycle still counts as an underrun. The pushed sample is retained for the next period.
- Edge-aligned compare: output is high while `cnt` < `duty`.
- Center-aligned compare:
  - `lo` = 2^(CODE_WIDTH-1) - (`duty`>>1), computed CODE_WIDTH+1 bits wide;
  - output is high while `lo` <= `cnt` < `lo` + `duty`.
- Duty limits: 100% duty is unreachable, since the maximum code gives (2^W-1)/2^W. A duty of 0 gives a constant low.
- Reset values (asynchronous):
  - `pwm_out`=0, `underrun`=0, `underrun_cnt`=0;
  - `fifo_level`=0, `in_ready`=1;
  - `cnt`=0, `duty`=0, `mode_q`=0, `mute_q`=0.
- Reset mid-operation discards FIFO contents and aborts the current period.

## Timing
- `pwm_out` is the compare result of `cnt`/`duty` registered, so it lags `cnt` by one cycle.
- Boundary cycle B loads the new duty. Cycle B+1 (`cnt`=0) compares against it. `pwm_out` reflects the new sample from B+2.
- Sample acceptance to first effect on `pwm_out` is at most 2^CODE_WIDTH+2 cycles when the FIFO was empty.
- `underrun` is asserted exactly on cycle B+1. `underrun_cnt` is updated on B+1.
- `in_ready` rises in the same cycle a pop leaves the FIFO non-full (combinational from level).
- `fifo_level` updates on the cycle after a push or pop.

## Configuration
- Macro: `PWM_DAC_UNDERRUN_MIDSCALE_EN`.
- Defined: on underrun, `duty` loads midscale 2^(CODE_WIDTH-1), which gives silence at DC midpoint. `mute` still overrides it to 0.
- Undefined: on underrun, `duty` holds the last loaded value.
- Underrun pulse and count behaviour are identical in both builds.

## Test plan
All scenarios use CODE_WIDTH=4 (period 16) and FIFO_DEPTH=4.
- Basic edge PWM:
  - Stimulus: push code 5 after reset.
  - Response: starting at the first boundary B, `pwm_out` is high for cycles B+2..B+6 (5 cycles) and low for the next 11, repeating.
- Center mode:
  - Stimulus: `center_mode`=1, push code 6.
  - Response: `lo`=5, so `pwm_out` is high on the cycles following `cnt`=5..10 (6 cycles) each period.
- Fill and backpressure:
  - Stimulus: hold `in_valid`=1 with no boundary.
  - Response: 4 pushes are accepted, then `fifo_level`=4 and `in_ready`=0. After the next boundary, `in_ready`=1 and `fifo_level`=3.
- Underrun:
  - Stimulus: push 7 once and let 3 boundaries pass.
  - Response: `underrun` pulses twice and `underrun_cnt`=2. Duty stays 7 when the macro is undefined, or becomes 8 when defined.
- Mute and reset:
  - Stimulus: `mute`=1 with the FIFO full, 4 periods.
  - Response: `pwm_out` is constantly 0, the FIFO drains to 0, and there is no underrun until the 5th boundary.
  - Then: assert `rst_n`=0 mid-period. All outputs are at reset values within that cycle.
